// File: rtl/ring_out_arbiter.sv
// ring_out_arbiter: two-VC ring output stage with per-VC one-entry buffers, ring/PE round-robin and polarity-phased drain
module ring_out_arbiter #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  req_ring_even,
  input  logic                  req_ring_odd,
  input  logic                  req_pe_even,
  input  logic                  req_pe_odd,
  input  logic [DATA_WIDTH-1:0] data_ring_even,
  input  logic [DATA_WIDTH-1:0] data_ring_odd,
  input  logic [DATA_WIDTH-1:0] data_pe_even,
  input  logic [DATA_WIDTH-1:0] data_pe_odd,
  output logic                  grant_ring_even,
  output logic                  grant_ring_odd,
  output logic                  grant_pe_even,
  output logic                  grant_pe_odd,
  input  logic                  ro,
  output logic                  so,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full_even,
  output logic                  full_odd
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t                st_q [2];
  state_t                st_d [2];
  logic [1:0]            req_r, req_p, prio_q, prio_d, gr_q, gr_d, gp_q, gp_d;
  logic [DATA_WIDTH-1:0] dat_r [2];
  logic [DATA_WIDTH-1:0] dat_p [2];
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [DATA_WIDTH-1:0] do_q, do_d;
  logic                  so_q, so_d;
  assign req_r    = {req_ring_odd, req_ring_even};
  assign req_p    = {req_pe_odd, req_pe_even};
  assign dat_r[0] = data_ring_even;
  assign dat_r[1] = data_ring_odd;
  assign dat_p[0] = data_pe_even;
  assign dat_p[1] = data_pe_odd;
  // VC index doubles as the polarity value that lets it drain, so only one VC can ever hit so
  always_comb begin
    so_d = 1'b0;
    do_d = do_q;
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      buf_d[i]  = buf_q[i];
      prio_d[i] = prio_q[i];
      gr_d[i]   = 1'b0;
      gp_d[i]   = 1'b0;
      if (st_q[i] == EMPTY && (req_r[i] || req_p[i])) begin
        gp_d[i]   = req_p[i] && (!req_r[i] || prio_q[i]);
        gr_d[i]   = !gp_d[i];
        prio_d[i] = prio_q[i] ^ (req_r[i] && req_p[i]);
        buf_d[i]  = gp_d[i] ? dat_p[i] : dat_r[i];
        st_d[i]   = FULL;
      end
      if (st_q[i] == FULL && ro && polarity == (i == 1)) begin
        st_d[i] = EMPTY;
        so_d    = 1'b1;
        do_d    = buf_q[i];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '{EMPTY, EMPTY};
      buf_q  <= '{default: '0};
      prio_q <= '0;
      gr_q   <= '0;
      gp_q   <= '0;
      so_q   <= 1'b0;
      do_q   <= '0;
    end else begin
      st_q   <= st_d;
      buf_q  <= buf_d;
      prio_q <= prio_d;
      gr_q   <= gr_d;
      gp_q   <= gp_d;
      so_q   <= so_d;
      do_q   <= do_d;
    end
  end
  assign grant_ring_even = gr_q[0];
  assign grant_ring_odd  = gr_q[1];
  assign grant_pe_even   = gp_q[0];
  assign grant_pe_odd    = gp_q[1];
  assign so              = so_q;
  assign dout            = do_q;
  assign full_even       = st_q[0] == FULL;
  assign full_odd        = st_q[1] == FULL;
endmodule

// File: tb/tb_ring_out_arbiter.sv
// tb_ring_out_arbiter: directed scenarios plus random traffic checked every cycle against a flit-level model
module tb_ring_out_arbiter;
  logic        clk = 1'b0, rst = 1'b1, polarity = 1'b0, ro = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] dat [4];
  logic        gre, gro, gpe, gpo, so, full_even, full_odd;
  logic [63:0] dout;
  int          n_cmp = 0, n_err = 0;
  // model: per VC an occupancy flag, the held flit and the ring/PE turn
  logic [1:0]  m_occ, occ0, m_prio;
  logic [63:0] m_buf [2];
  logic [3:0]  m_g;
  logic        m_so;
  logic [63:0] m_do;
  int          s;
  logic [3:0]  gl [8];
  logic [63:0] dl [8];
  int          ng, nd, nso;

  ring_out_arbiter #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .polarity(polarity),
    .req_ring_even(req[0]), .req_ring_odd(req[2]), .req_pe_even(req[1]), .req_pe_odd(req[3]),
    .data_ring_even(dat[0]), .data_ring_odd(dat[2]), .data_pe_even(dat[1]), .data_pe_odd(dat[3]),
    .grant_ring_even(gre), .grant_ring_odd(gro), .grant_pe_even(gpe), .grant_pe_odd(gpo),
    .ro(ro), .so(so), .dout(dout), .full_even(full_even), .full_odd(full_odd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_occ = '0; m_prio = '0; m_g = '0; m_so = 1'b0; m_do = '0;
      m_buf[0] = '0; m_buf[1] = '0;
    end else begin
      occ0 = m_occ;
      m_g  = '0;
      m_so = 1'b0;
      for (int v = 0; v < 2; v++) begin
        if (occ0[v] && ro && polarity == v[0]) begin
          m_so = 1'b1; m_do = m_buf[v]; m_occ[v] = 1'b0;
        end else if (!occ0[v] && (req[2*v] || req[2*v+1])) begin
          s = 2*v + ((req[2*v+1] && (!req[2*v] || m_prio[v])) ? 1 : 0);
          if (req[2*v] && req[2*v+1]) m_prio[v] = !m_prio[v];
          m_g[s] = 1'b1; m_buf[v] = dat[s]; m_occ[v] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("so", {63'd0, so}, {63'd0, m_so});
    chk("do", dout, m_do);
    chk("grants", {60'd0, gpo, gro, gpe, gre}, {60'd0, m_g});
    chk("full", {62'd0, full_odd, full_even}, {62'd0, m_occ});
  end

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req[0] = 1'b1; dat[0] = 64'hA5; polarity = 1'b0; ro = 1'b1;
    @(negedge clk);
    chk("t28_grant", {60'd0, gpo, gro, gpe, gre}, 64'b0001);
    chk("t28_full", {63'd0, full_even}, 64'd1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t28_so", {63'd0, so}, 64'd1);
    chk("t28_do", dout, 64'hA5);
    req[2] = 1'b1; req[3] = 1'b1; dat[2] = 64'h1; dat[3] = 64'h2; polarity = 1'b0;
    ng = 0; nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if ({gpo, gro, gpe, gre} != 4'b0 && ng < 8) begin gl[ng] = {gpo, gro, gpe, gre}; ng++; end
      if (so && nd < 8) begin dl[nd] = dout; nd++; end
      polarity = ~polarity;
    end
    req[3:2] = 2'b00;
    chk("t29_ngrants", 64'(ng), 64'd3);
    chk("t29_nflits", 64'(nd), 64'd3);
    if (ng >= 3) begin
      chk("t29_g0", {60'd0, gl[0]}, 64'b0100);
      chk("t29_g1", {60'd0, gl[1]}, 64'b1000);
      chk("t29_g2", {60'd0, gl[2]}, 64'b0100);
    end
    if (nd >= 3) begin
      chk("t29_d0", dl[0], 64'h1);
      chk("t29_d1", dl[1], 64'h2);
      chk("t29_d2", dl[2], 64'h1);
    end
    polarity = 1'b0; ro = 1'b0; req[0] = 1'b1; dat[0] = 64'hBEEF;
    @(negedge clk);
    req[0] = 1'b0;
    nso = 0;
    repeat (5) begin
      @(negedge clk);
      nso += int'(so);
      chk("t30_do_hold", dout, 64'h1);
      chk("t30_nogrant", {60'd0, gpo, gro, gpe, gre}, 64'd0);
    end
    chk("t30_nso", 64'(nso), 64'd0);
    chk("t30_full", {63'd0, full_even}, 64'd1);
    ro = 1'b1;
    @(negedge clk);
    chk("t30_so", {63'd0, so}, 64'd1);
    chk("t30_do", dout, 64'hBEEF);
    @(negedge clk);
    chk("t30_so_once", {63'd0, so}, 64'd0);
    polarity = 1'b1; req[1] = 1'b1; dat[1] = 64'h33;
    @(negedge clk);
    req[1] = 1'b0; req[2] = 1'b1; dat[2] = 64'h44;
    @(negedge clk);
    req[2] = 1'b0;
    chk("t31_held", {63'd0, so}, 64'd0);
    @(negedge clk);
    chk("t31_odd_so", {63'd0, so}, 64'd1);
    chk("t31_odd_do", dout, 64'h44);
    chk("t31_even_full", {63'd0, full_even}, 64'd1);
    polarity = 1'b0;
    @(negedge clk);
    chk("t31_even_so", {63'd0, so}, 64'd1);
    chk("t31_even_do", dout, 64'h33);
    chk("t31_even_empty", {63'd0, full_even}, 64'd0);
    ro = 1'b0; req[0] = 1'b1; req[2] = 1'b1; dat[0] = 64'h7; dat[2] = 64'h8;
    @(negedge clk);
    req[0] = 1'b0; req[2] = 1'b0;
    chk("t32_both_full", {62'd0, full_odd, full_even}, 64'b11);
    #2 rst = 1'b1;
    #1 chk("t32_async_full", {62'd0, full_odd, full_even}, 64'd0);
    chk("t32_async_so", {63'd0, so}, 64'd0);
    @(negedge clk);
    rst = 1'b0; req[0] = 1'b1; req[1] = 1'b1; dat[1] = 64'h9;
    @(negedge clk);
    chk("t32_ring_first", {60'd0, gpo, gro, gpe, gre}, 64'b0001);
    req[1:0] = 2'b00;
    repeat (3000) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (req[k] && m_g[k]) req[k] = 1'b0;
        else if (!req[k] && $urandom_range(0, 2) == 0) begin
          req[k] = 1'b1;
          dat[k] = {$urandom, $urandom};
        end
      end
      polarity = 1'($urandom_range(0, 1));
      ro = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ring_out_arbiter.md
RING_OUT_ARBITER -- requirements
Module: ring_out_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, setting the flit width.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 polarity  input  1  link phase; 0 selects the even virtual channel (VC) for transmit, 1 selects the odd VC.
REQ-005 req_ring_even, req_ring_odd  input  1 each  pass-through buffer has a flit for the even/odd VC.
REQ-006 req_pe_even, req_pe_odd  input  1 each  PE injection buffer has a flit for the even/odd VC.
REQ-007 data_ring_even, data_ring_odd, data_pe_even, data_pe_odd  input  DATA_WIDTH each  flit offered with the matching request.
REQ-008 grant_ring_even, grant_ring_odd, grant_pe_even, grant_pe_odd  output  1 each  registered one-cycle pulse: flit has been taken.
REQ-009 ro  input  1  downstream link ready.
REQ-010 so  output  1  registered one-cycle pulse: flit valid on do.
REQ-011 do  output  DATA_WIDTH  registered outgoing flit.
REQ-012 full_even, full_odd  output  1 each  one-entry VC output buffer occupied.

Function
REQ-013 Each VC SHALL own a one-entry output buffer and an independent two-state FSM: EMPTY, FULL.
REQ-014 EMPTY -> FULL at an edge where at least one request of that VC is high; the chosen flit is written into the buffer at that edge.
REQ-015 The granted requester's grant SHALL be high for exactly the cycle following the capture edge; all other grants SHALL be 0.
REQ-016 In FULL, requests SHALL be ignored; no grant SHALL issue. Load and drain SHALL NOT happen on the same edge, so there is a minimum one-cycle bubble between flits per VC.
REQ-017 Single request: that source SHALL be granted regardless of priority.
REQ-018 Both requests high: the source indicated by the VC's priority bit SHALL be granted (0 = ring, 1 = PE), and the priority bit SHALL then toggle. The bit SHALL NOT change on uncontended grants.
REQ-019 FULL -> EMPTY at an edge where ro==1 and the polarity matches the VC (even: polarity==0; odd: polarity==1). At that edge do SHALL load the buffer contents and so SHALL go to 1 for one cycle.
REQ-020 At most one VC SHALL transmit per edge; this is guaranteed by polarity.
REQ-021 If no transmit occurs, so SHALL be 0 and do SHALL hold its last value.
REQ-022 FULL with ro==0 or the wrong polarity: the buffer SHALL hold its contents indefinitely, with no loss or duplication.
REQ-023 Minimum latency SHALL be 2 edges from request sampled to so high (capture edge, then the first eligible drain edge).
REQ-024 The even and odd VCs SHALL operate concurrently: one VC may load while the other drains on the same edge.
REQ-025 Requesters SHALL deassert their request in the cycle they see the grant. The arbiter relies on the FULL state, not on the request dropping, to avoid a double grant.

Reset
REQ-026 rst high SHALL immediately force both FSMs to EMPTY, both priority bits to 0 (ring first), all grants to 0, so to 0, do to 0, full_even and full_odd to 0, and the buffers to 0.
REQ-027 Asserting reset mid-operation SHALL discard buffered flits. No grant or so SHALL occur while rst is high, nor on the first edge after release unless its conditions are met.

Verification
REQ-028 After reset, req_ring_even=1 with data 64'hA5, polarity=0, ro=1: grant_ring_even pulses in cycle 1, full_even=1, then so=1 with do=64'hA5 in cycle 2.
REQ-029 req_ring_odd and req_pe_odd both held high, with ring data 64'h1 and PE data 64'h2, polarity toggling each cycle, ro=1: grants alternate ring, PE, ring, and do sequence is 1, 2, 1.
REQ-030 Even buffer FULL, ro=0 for 5 cycles: so stays 0, do holds, no grants. Then ro=1 with polarity=0: a single so pulse carries the buffered flit.
REQ-031 Even buffer FULL, polarity=1 held, ro=1: no even transmit until polarity=0. An odd flit loaded meanwhile drains in the polarity=1 cycles.
REQ-032 Assert rst while both buffers are FULL: full_even and full_odd go 0 asynchronously and so stays 0. After release, with both PE and ring requests high, ring is granted first.
